// File: rtl/bit_idx_streamer_if.sv
// bit_idx_streamer_if: mask-in / index-out valid-ready stream bundle
interface bit_idx_streamer_if #(parameter int CNT_W = 8);
  logic             i_valid;
  logic             o_ready;
  logic [127:0]     i_data;
  logic             o_valid;
  logic             i_ready;
  logic [6:0]       o_idx;
  logic             o_last;
  logic [CNT_W-1:0] o_cnt;
  logic             o_done;
  modport slave (input i_valid, i_data, i_ready, output o_ready, o_valid, o_idx, o_last, o_cnt, o_done);
  modport master (output i_valid, i_data, i_ready, input o_ready, o_valid, o_idx, o_last, o_cnt, o_done);
endinterface

// File: rtl/bit_idx_streamer.sv
// bit_idx_streamer: streams ascending set-bit indices of a 128-bit mask, 4 resolved per scan
// Optional synchronous flush input enabled by defining IDX_STREAM_FLUSH_EN.
module bit_idx_streamer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input logic i_clk,
  input logic i_rst_n,
`ifdef IDX_STREAM_FLUSH_EN
  input logic i_flush,
`endif
  bit_idx_streamer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rdy_q;
  logic [127:0]     mask_q, mask_d;
  logic [6:0]       idx_q [FIFO_DEPTH];
  logic             last_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic [CNT_W-1:0] pops_q;
  logic             done_q, done_d;
  logic [127:0]     m [5];
  logic [6:0]       fidx [4];
  logic [3:0]       fv;
  logic [2:0]       npush;
  logic             flush, accept, pop, push_ok;

`ifdef IDX_STREAM_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  function automatic logic [6:0] lsb(input logic [127:0] v);
    lsb = '0;
    for (int i = 127; i >= 0; i--) if (v[i]) lsb = 7'(i);
  endfunction

  // four cascaded lowest-set-bit finders, each clearing the bit it found
  always_comb begin
    m[0] = mask_q;
    for (int k = 0; k < 4; k++) begin
      fv[k]    = |m[k];
      fidx[k]  = lsb(m[k]);
      m[k + 1] = m[k] & (m[k] - 128'd1);
    end
    npush = 3'(fv[0]) + 3'(fv[1]) + 3'(fv[2]) + 3'(fv[3]);
  end

  assign bus.o_ready = (state_q == IDLE) & rdy_q;
  assign bus.o_valid = |cnt_q;
  assign bus.o_idx   = bus.o_valid ? idx_q[rd_q] : '0;
  assign bus.o_last  = bus.o_valid & last_q[rd_q];
  assign bus.o_cnt   = pops_q;
  assign bus.o_done  = done_q;

  assign accept  = bus.i_valid & bus.o_ready & ~flush;
  assign pop     = bus.o_valid & bus.i_ready & ~flush;
  // free slots come from the registered occupancy only; a same-cycle pop does not help
  assign push_ok = (state_q == SCAN) & (|mask_q) & (cnt_q <= (AW+1)'(FIFO_DEPTH - 4)) & ~flush;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      mask_d  = '0;
      done_d  = 1'b1;
    end else if (accept) begin
      state_d = SCAN;
      mask_d  = bus.i_data;
    end else if (state_q == SCAN && mask_q == '0) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (push_ok) begin
      mask_d  = m[4];
      state_d = (m[4] == '0) ? DRAIN : SCAN;
    end else if (state_q == DRAIN && pop && last_q[rd_q]) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      mask_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      pops_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      mask_q  <= mask_d;
      done_q  <= done_d;
      if (flush) begin
        wr_q   <= '0;
        rd_q   <= '0;
        cnt_q  <= '0;
        pops_q <= '0;
      end else begin
        wr_q   <= wr_q + (push_ok ? AW'(npush) : '0);
        rd_q   <= rd_q + AW'(pop);
        cnt_q  <= cnt_q + (push_ok ? (AW+1)'(npush) : '0) - (AW+1)'(pop);
        pops_q <= accept ? '0 : (pop && pops_q != CNT_W'(128)) ? pops_q + CNT_W'(1) : pops_q;
      end
    end
  end

  // an entry is last when no set bit remains above it in the working mask
  always_ff @(posedge i_clk) begin
    if (push_ok)
      for (int k = 0; k < 4; k++)
        if (fv[k]) begin
          idx_q[wr_q + AW'(k)]  <= fidx[k];
          last_q[wr_q + AW'(k)] <= ~|m[k + 1];
        end
  end
endmodule
